instruction_fetch_unit: RTL and testbench

Fetch stage that sits directly upstream of `instruction_decoder`. It owns the program counter and issues word fetches to instruction memory over a valid/ready request channel. In-order responses are buffered in a small prefetch FIFO, and each 32-bit instruction is presented with its PC to the decode stage over a valid/ready handshake. Branch/jump redirects flush the FIFO and discard in-flight responses.

---
 rtl/instruction_fetch_unit_if.sv | 34 +++
 rtl/instruction_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input,
// and the fetched-instruction channel toward decode. "master" is the fetch unit side.
interface instruction_fetch_unit_if;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic [31:0] fetch_count;

   // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
   // valid never waits on ready, and addr/data stay stable while valid & !ready.
   modport master (
      output imem_req_valid, imem_req_addr,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
      input  redirect_valid, redirect_pc,
      output inst_valid, inst_data, inst_pc, fetch_count,
      input  inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
      output redirect_valid, redirect_pc,
      input  inst_valid, inst_data, inst_pc, fetch_count,
      output inst_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: PC, credit-limited imem requests, prefetch FIFO, redirect flush.
// Define IFU_PERF_COUNTER_EN to build the delivered-instruction counter behind fetch_count.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   instruction_fetch_unit_if.master  bus,
   output logic [0:0]                dbg_state_o
);
   localparam int              CW      = $clog2(FIFO_DEPTH + 1);
   localparam int              PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]   ONE_C   = CW'(1);
   localparam logic [PW-1:0]   PONE_C  = PW'(1);
   localparam logic [0:0]      ST_BOOT = 1'b0;
   localparam logic [0:0]      ST_RUN  = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] out_q, out_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [31:0]   mem_data [FIFO_DEPTH];
   logic [31:0]   mem_pc   [FIFO_DEPTH];
   logic [CW:0]   credit;
   logic [31:0]   redir_tgt;
   logic          req_fire, rsp_fire, push, pop;

   // Outstanding requests reserve FIFO slots, so a push can never find the FIFO full.
   assign credit             = {1'b0, out_q} + {1'b0, cnt_q};
   assign bus.imem_req_valid = (state_q == ST_RUN) && (credit < DEPTH_C);
   assign bus.imem_req_addr  = fetch_pc_q;
   assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
   assign rsp_fire           = bus.imem_rsp_valid;
   assign redir_tgt          = bus.redirect_pc & 32'hFFFF_FFFC;
   assign push               = rsp_fire && (drop_q == '0) && !bus.redirect_valid;

   assign bus.inst_valid = (cnt_q != '0);
   assign pop            = bus.inst_valid & bus.inst_ready;
   assign bus.inst_data  = bus.inst_valid ? mem_data[rd_q] : 32'h0;
   assign bus.inst_pc    = bus.inst_valid ? mem_pc[rd_q]   : 32'h0;
   assign dbg_state_o    = state_q;

   always_comb begin
      state_d    = ST_RUN;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      out_d      = out_q;
      drop_d     = drop_q;
      cnt_d      = cnt_q;
      rd_d       = rd_q;
      wr_d       = wr_q;
      if (req_fire)
         fetch_pc_d = fetch_pc_q + 32'd4;
      if (req_fire && !rsp_fire)
         out_d = out_q + ONE_C;
      else if (!req_fire && rsp_fire)
         out_d = out_q - ONE_C;
      // Everything still in flight after this cycle belongs to the old stream.
      if (bus.redirect_valid) begin
         fetch_pc_d = redir_tgt;
         rsp_pc_d   = redir_tgt;
         drop_d     = out_d;
         cnt_d      = '0;
         rd_d       = '0;
         wr_d       = '0;
      end else begin
         if (rsp_fire && (drop_q != '0))
            drop_d = drop_q - ONE_C;
         if (push) begin
            rsp_pc_d = rsp_pc_q + 32'd4;
            wr_d     = wr_q + PONE_C;
         end
         if (pop)
            rd_d = rd_q + PONE_C;
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + ONE_C;
            2'b01:   cnt_d = cnt_q - ONE_C;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_q      <= '0;
         drop_q     <= '0;
         cnt_q      <= '0;
         rd_q       <= '0;
         wr_q       <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         cnt_q      <= cnt_d;
         rd_q       <= rd_d;
         wr_q       <= wr_d;
      end
   end

   // Storage needs no reset: the head is masked whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_q] <= bus.imem_rsp_data;
         mem_pc[wr_q]   <= rsp_pc_q;
      end
   end

`ifdef IFU_PERF_COUNTER_EN
   logic [31:0] fetch_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fetch_count_q <= 32'h0;
      else if (pop)
         fetch_count_q <= fetch_count_q + 32'd1;
   end

   assign bus.fetch_count = fetch_count_q;
`else
   assign bus.fetch_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: behavioural imem with variable latency,
// in-order scoreboard of expected PCs/words, and linear directed stimulus.
module tb_instruction_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef IFU_PERF_COUNTER_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   typedef struct {
      int unsigned due;
      logic [31:0] addr;
   } pend_t;

   logic        clk;
   logic        rst_n;
   logic [0:0]  dbg_state;
   int          n_cmp;
   int          n_err;
   int          hs_cnt;
   int          fc_base;
   int unsigned cyc;
   int unsigned mem_lat;
   bit          ready_rand;
   pend_t       pend_q[$];
   logic [31:0] exp_q[$];

   instruction_fetch_unit_if bus_if ();

   instruction_fetch_unit #(
      .RESET_PC   (RST_PC),
      .FIFO_DEPTH (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_if),
      .dbg_state_o (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever @(posedge clk) cyc++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: observed no finish, required finish before timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ {a[31:16], 16'h0} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   function automatic void fill_stream(input logic [31:0] start);
      logic [31:0] pc;
      exp_q.delete();
      pc = start & 32'hFFFF_FFFC;
      for (int i = 0; i < 1500; i++) begin
         exp_q.push_back(pc);
         pc = pc + 32'd4;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_insts(input string tag, input int n, input int budget);
      int target;
      int k;
      target = hs_cnt + n;
      k = 0;
      while (hs_cnt < target && k < budget) begin
         step();
         k++;
      end
      chk(tag, (hs_cnt >= target) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      bus_if.redirect_valid = 1'b1;
      bus_if.redirect_pc    = tgt;
      step();
      bus_if.redirect_valid = 1'b0;
   endtask

   // ---------------- instruction memory model (driver) ----------------
   initial begin : imem_model
      bit          rdy;
      bit          prev_stall;
      bit          prev_redir;
      logic [31:0] prev_addr;
      bus_if.imem_req_ready = 1'b0;
      bus_if.imem_rsp_valid = 1'b0;
      bus_if.imem_rsp_data  = 32'h0;
      prev_stall = 1'b0;
      prev_redir = 1'b0;
      prev_addr  = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pend_q.delete();
            bus_if.imem_rsp_valid = 1'b0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && !prev_redir)
               chk("req_addr_stable", bus_if.imem_req_addr, prev_addr);
            rdy = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            bus_if.imem_req_ready = rdy;
            if (bus_if.imem_req_valid && rdy)
               pend_q.push_back('{due: cyc + mem_lat, addr: bus_if.imem_req_addr});
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
               bus_if.imem_rsp_valid = 1'b1;
               bus_if.imem_rsp_data  = mem_word(pend_q[0].addr);
               void'(pend_q.pop_front());
            end else begin
               bus_if.imem_rsp_valid = 1'b0;
               bus_if.imem_rsp_data  = 32'hDEAD_BEEF;
            end
            prev_stall = bus_if.imem_req_valid && !rdy;
            prev_addr  = bus_if.imem_req_addr;
            prev_redir = bus_if.redirect_valid;
         end
      end
   end

   // ---------------- scoreboard ----------------
   initial begin : scoreboard
      bit          prev_hold;
      bit          prev_redir;
      logic [31:0] hold_data;
      logic [31:0] hold_pc;
      logic [31:0] e;
      prev_hold  = 1'b0;
      prev_redir = 1'b0;
      hold_data  = 32'h0;
      hold_pc    = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_hold = 1'b0;
         end else begin
            if (prev_hold && !prev_redir) begin
               chk("hold_valid", {31'h0, bus_if.inst_valid}, 32'd1);
               chk("hold_data", bus_if.inst_data, hold_data);
               chk("hold_pc", bus_if.inst_pc, hold_pc);
            end
            if (bus_if.inst_valid && bus_if.inst_ready) begin
               if (exp_q.size() == 0) begin
                  chk("sb_underflow", 32'd0, 32'd1);
               end else begin
                  e = exp_q.pop_front();
                  chk("inst_pc", bus_if.inst_pc, e);
                  chk("inst_data", bus_if.inst_data, mem_word(e));
               end
               hs_cnt++;
            end
            if (bus_if.redirect_valid)
               fill_stream(bus_if.redirect_pc);
            prev_hold  = bus_if.inst_valid && !bus_if.inst_ready;
            prev_redir = bus_if.redirect_valid;
            hold_data  = bus_if.inst_data;
            hold_pc    = bus_if.inst_pc;
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin : stimulus
      int k;
      int base;
      n_cmp = 0;
      n_err = 0;
      hs_cnt = 0;
      fc_base = 0;
      mem_lat = 1;
      ready_rand = 1'b0;
      rst_n = 1'b0;
      bus_if.redirect_valid = 1'b0;
      bus_if.redirect_pc    = 32'h0;
      bus_if.inst_ready     = 1'b0;
      fill_stream(RST_PC);
      repeat (3) step();

      // Reset state
      chk("rst_req_valid", {31'h0, bus_if.imem_req_valid}, 32'd0);
      chk("rst_req_addr", bus_if.imem_req_addr, RST_PC);
      chk("rst_inst_valid", {31'h0, bus_if.inst_valid}, 32'd0);
      chk("rst_inst_data", bus_if.inst_data, 32'h0);
      chk("rst_inst_pc", bus_if.inst_pc, 32'h0);
      chk("rst_fetch_count", bus_if.fetch_count, 32'h0);
      chk("rst_state", {31'h0, dbg_state}, 32'd0);

      // Release: BOOT for one edge, then the first request at RESET_PC
      bus_if.inst_ready = 1'b1;
      rst_n = 1'b1;
      #1;
      chk("boot_no_req", {31'h0, bus_if.imem_req_valid}, 32'd0);
      step();
      chk("first_req_valid", {31'h0, bus_if.imem_req_valid}, 32'd1);
      chk("first_req_addr", bus_if.imem_req_addr, RST_PC);
      chk("run_state", {31'h0, dbg_state}, 32'd1);
      wait_insts("stream_fill", 20, 200);

      // Decode stall: credits run out, head held, nothing lost on release
      bus_if.inst_ready = 1'b0;
      repeat (10) step();
      chk("stall_no_req", {31'h0, bus_if.imem_req_valid}, 32'd0);
      chk("stall_valid", {31'h0, bus_if.inst_valid}, 32'd1);
      chk("stall_head_pc", bus_if.inst_pc, exp_q[0]);
      bus_if.inst_ready = 1'b1;
      wait_insts("stall_release", 10, 100);

      // Redirect with two responses in flight (3-cycle memory)
      mem_lat = 3;
      k = 0;
      while (pend_q.size() != 2 && k < 100) begin
         step();
         k++;
      end
      chk("two_in_flight", pend_q.size(), 32'd2);
      redirect(32'h0000_2000);
      chk("redir_inst_valid", {31'h0, bus_if.inst_valid}, 32'd0);
      chk("redir_req_addr", bus_if.imem_req_addr, 32'h0000_2000);
      wait_insts("redir_stream", 5, 100);

      // Redirect coinciding with a request accept and a response arrival
      mem_lat = 1;
      k = 0;
      while (!(bus_if.imem_req_valid && pend_q.size() > 0 && pend_q[0].due <= cyc) && k < 100) begin
         step();
         k++;
      end
      chk("coincide_found", (k < 100) ? 32'd1 : 32'd0, 32'd1);
      redirect(32'h0000_4003);
      chk("coincide_inst_valid", {31'h0, bus_if.inst_valid}, 32'd0);
      chk("coincide_req_addr", bus_if.imem_req_addr, 32'h0000_4000);
      wait_insts("coincide_stream", 5, 100);

      // Random request backpressure, 3-cycle latency, random decode readiness
      mem_lat = 3;
      ready_rand = 1'b1;
      base = hs_cnt;
      k = 0;
      while (hs_cnt < base + 1000 && k < 20000) begin
         bus_if.inst_ready = ($urandom_range(0, 3) != 0);
         step();
         k++;
      end
      chk("random_1000", (hs_cnt >= base + 1000) ? 32'd1 : 32'd0, 32'd1);
      ready_rand = 1'b0;
      bus_if.inst_ready = 1'b1;

      // PC wrap at the top of the address space
      redirect(32'hFFFF_FFF8);
      chk("wrap_req_addr", bus_if.imem_req_addr, 32'hFFFF_FFF8);
      wait_insts("wrap_stream", 6, 100);

      // Delivered-instruction counter
      bus_if.inst_ready = 1'b0;
      step();
      step();
      chk("fetch_count", bus_if.fetch_count, PERF_EN ? 32'(hs_cnt - fc_base) : 32'h0);

      // Asynchronous reset mid-operation
      bus_if.inst_ready = 1'b1;
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req_valid", {31'h0, bus_if.imem_req_valid}, 32'd0);
      chk("mid_rst_req_addr", bus_if.imem_req_addr, RST_PC);
      chk("mid_rst_inst_valid", {31'h0, bus_if.inst_valid}, 32'd0);
      chk("mid_rst_fetch_count", bus_if.fetch_count, 32'h0);
      chk("mid_rst_state", {31'h0, dbg_state}, 32'd0);
      fill_stream(RST_PC);
      fc_base = hs_cnt;
      step();
      rst_n = 1'b1;
      step();
      chk("rerun_req_valid", {31'h0, bus_if.imem_req_valid}, 32'd1);
      chk("rerun_req_addr", bus_if.imem_req_addr, RST_PC);
      wait_insts("rerun_stream", 5, 100);
      bus_if.inst_ready = 1'b0;
      step();
      step();
      chk("rerun_fetch_count", bus_if.fetch_count, PERF_EN ? 32'(hs_cnt - fc_base) : 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
